npu_mac4_accum: RTL and testbench

- Consumer stage directly downstream of the four-lane 8-bit input buffer.
- Each beat, multiplies the buffered activations QA..QD by four 8-bit weights and sums the four products into a dot product.
- Accumulates that dot product over a programmable number of beats, then saturates the result to 16 bits.
- Presents the result to the output/activation stage with a one-cycle DONE pulse.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/npu_dot4.sv | 31 +++
 rtl/npu_mac4_accum.sv | 144 ++++++++++++++
 tb/tb_npu_mac4_accum.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared constants and FSM encoding for the NPU MAC datapath blocks.
package npu_pkg;

  // Default widths; modules take these as parameter defaults.
  localparam int unsigned IN_W_DEF  = 8;
  localparam int unsigned ACC_W_DEF = 26;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  // Saturation bounds for the default output width.
  localparam int OUT_MAX = (2 ** (OUT_W_DEF - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W_DEF - 1));

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StFin  = 2'd2
  } state_e;

endpackage

// File: rtl/npu_dot4.sv
// Combinational 4-lane signed multiply with adder tree; result is 2*IN_W+2 bits wide,
// enough for four full-range signed products without overflow.
module npu_dot4
  import npu_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  localparam int unsigned SUM_W = 2 * IN_W + 2
) (
  input  logic signed [IN_W-1:0]  qa,
  input  logic signed [IN_W-1:0]  qb,
  input  logic signed [IN_W-1:0]  qc,
  input  logic signed [IN_W-1:0]  qd,
  input  logic signed [IN_W-1:0]  wa,
  input  logic signed [IN_W-1:0]  wb,
  input  logic signed [IN_W-1:0]  wc,
  input  logic signed [IN_W-1:0]  wd,
  output logic signed [SUM_W-1:0] sum
);

  logic signed [2*IN_W-1:0] pa, pb, pc, pd;

  // Lane products, then a balanced two-level sum of sign-extended products.
  always_comb begin
    pa  = qa * wa;
    pb  = qb * wb;
    pc  = qc * wc;
    pd  = qd * wd;
    sum = (SUM_W'(pa) + SUM_W'(pb)) + (SUM_W'(pc) + SUM_W'(pd));
  end

endmodule

// File: rtl/npu_mac4_accum.sv
// Four-lane MAC accumulator: sums per-beat dot products over NUM_BEATS beats, then
// saturates to OUT_W bits and pulses DONE.
// Optional macro MAC_RELU_EN: rectify the saturated result (negatives become 0).
module npu_mac4_accum
  import npu_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLKEXT,
  input  logic             CLR_MAC,
  input  logic             START,
  input  logic [CNT_W-1:0] NUM_BEATS,
  input  logic             DATA_VALID,
  input  logic [IN_W-1:0]  QA,
  input  logic [IN_W-1:0]  QB,
  input  logic [IN_W-1:0]  QC,
  input  logic [IN_W-1:0]  QD,
  input  logic [IN_W-1:0]  WA,
  input  logic [IN_W-1:0]  WB,
  input  logic [IN_W-1:0]  WC,
  input  logic [IN_W-1:0]  WD,
  output logic             BUSY,
  output logic             DONE,
  output logic [OUT_W-1:0] RESULT,
  output logic             SAT_FLAG
);

  localparam int unsigned SUM_W = 2 * IN_W + 2;

  // Clamp bounds sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_HI =
      {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
      {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     done_q;
  logic [OUT_W-1:0]         result_q;
  logic                     sat_q;
  logic signed [SUM_W-1:0]  dot_sum;
  logic signed [ACC_W-1:0]  dot_ext;
  logic [OUT_W-1:0]         res_d;
  logic                     sat_d;

  npu_dot4 #(
    .IN_W (IN_W)
  ) u_dot4 (
    .qa  ($signed(QA)),
    .qb  ($signed(QB)),
    .qc  ($signed(QC)),
    .qd  ($signed(QD)),
    .wa  ($signed(WA)),
    .wb  ($signed(WB)),
    .wc  ($signed(WC)),
    .wd  ($signed(WD)),
    .sum (dot_sum)
  );

  assign dot_ext = ACC_W'(dot_sum);

  // FSM state register.
  always_ff @(posedge CLKEXT) begin
    if (CLR_MAC) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next-state: START only honoured in idle; last accepted beat moves to finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = (NUM_BEATS == '0) ? StFin : StAcc;
      StAcc:   if (DATA_VALID && (cnt_q == CNT_W'(1))) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    BUSY     = (state_q != StIdle);
    DONE     = done_q;
    RESULT   = result_q;
    SAT_FLAG = sat_q;
  end

  // Output saturation (and optional rectification) of the accumulator.
  always_comb begin
    res_d = acc_q[OUT_W-1:0];
    sat_d = 1'b0;
    if (acc_q > SAT_HI) begin
      res_d = SAT_HI[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (acc_q < SAT_LO) begin
      res_d = SAT_LO[OUT_W-1:0];
      sat_d = 1'b1;
    end
`ifdef MAC_RELU_EN
    if (acc_q[ACC_W-1]) begin
      res_d = '0;
      sat_d = 1'b0;
    end
`else
`endif
  end

  // Datapath: accumulator, beat counter and the registered result/DONE pulse.
  always_ff @(posedge CLKEXT) begin
    if (CLR_MAC) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            acc_q <= '0;
            cnt_q <= NUM_BEATS;
          end
        end
        StAcc: begin
          if (DATA_VALID) begin
            acc_q <= acc_q + dot_ext;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StFin: begin
          done_q   <= 1'b1;
          result_q <= res_d;
          sat_q    <= sat_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_mac4_accum.sv
// Directed bench for npu_mac4_accum: vector table of complete jobs plus hand-written
// sequences for reset mid-job, stalls, zero-beat jobs and ignored START pulses.
module tb_npu_mac4_accum;

`ifdef MAC_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic        CLKEXT = 1'b0;
  logic        CLR_MAC, START, DATA_VALID;
  logic [7:0]  NUM_BEATS;
  logic [7:0]  QA, QB, QC, QD, WA, WB, WC, WD;
  logic        BUSY, DONE, SAT_FLAG;
  logic [15:0] RESULT;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]       n;
    logic [3:0][7:0]  q;
    logic [3:0][7:0]  w;
    logic [15:0]      res;
    logic             sat;
  } vec_t;

  vec_t vecs[12];

  always #5 CLKEXT = ~CLKEXT;

  npu_mac4_accum dut (
    .CLKEXT     (CLKEXT),
    .CLR_MAC    (CLR_MAC),
    .START      (START),
    .NUM_BEATS  (NUM_BEATS),
    .DATA_VALID (DATA_VALID),
    .QA         (QA),
    .QB         (QB),
    .QC         (QC),
    .QD         (QD),
    .WA         (WA),
    .WB         (WB),
    .WC         (WC),
    .WD         (WD),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .SAT_FLAG   (SAT_FLAG)
  );

  function automatic vec_t mk(input logic [7:0] n, input logic [31:0] q, input logic [31:0] w,
                              input logic [15:0] res, input logic sat);
    vec_t v;
    v.n = n; v.q = q; v.w = w; v.res = res; v.sat = sat;
    return v;
  endfunction

  task automatic tick;
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [3:0][7:0] q, input logic [3:0][7:0] w);
    QA = q[3]; QB = q[2]; QC = q[1]; QD = q[0];
    WA = w[3]; WB = w[2]; WC = w[1]; WD = w[0];
  endtask

  // Full job with DATA_VALID every cycle; checks DONE lands exactly N+1 edges after START.
  task automatic run_job(input vec_t v, input string name);
    set_lanes(v.q, v.w);
    START = 1'b1; NUM_BEATS = v.n; DATA_VALID = 1'b0;
    tick();
    START = 1'b0;
    check({name, " busy_after_start"}, 32'(BUSY), 32'd1);
    DATA_VALID = 1'b1;
    repeat (int'(v.n)) tick();
    DATA_VALID = 1'b0;
    check({name, " done_early"}, 32'(DONE), 32'd0);
    tick();
    check({name, " done"}, 32'(DONE), 32'd1);
    check({name, " busy_at_done"}, 32'(BUSY), 32'd0);
    check({name, " result"}, 32'(RESULT), 32'(v.res));
    check({name, " sat"}, 32'(SAT_FLAG), 32'(v.sat));
    tick();
    check({name, " done_one_cycle"}, 32'(DONE), 32'd0);
    check({name, " result_held"}, 32'(RESULT), 32'(v.res));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(8'd1,   32'h01020304, 32'h05060708, 16'd70,   1'b0);
    vecs[1]  = mk(8'd1,   32'h01010101, 32'h01010101, 16'd4,    1'b0);
    vecs[2]  = mk(8'd10,  32'h7F7F7F7F, 32'h7F7F7F7F, 16'h7FFF, 1'b1);
    vecs[3]  = mk(8'd10,  32'h80808080, 32'h7F7F7F7F,
                  Relu ? 16'h0000 : 16'h8000, !Relu);
    vecs[4]  = mk(8'd2,   32'hFFFEFDFC, 32'h01010101, Relu ? 16'h0000 : 16'hFFEC, 1'b0);
    vecs[5]  = mk(8'd1,   32'h7F7F7F01, 32'h7F7F0401, 16'h7FFF, 1'b0);
    vecs[6]  = mk(8'd1,   32'h7F7F7F01, 32'h7F7F0402, 16'h7FFF, 1'b1);
    vecs[7]  = mk(8'd1,   32'h80808000, 32'h7F7F0200, Relu ? 16'h0000 : 16'h8000, 1'b0);
    vecs[8]  = mk(8'd255, 32'h80808080, 32'h80808080, 16'h7FFF, 1'b1);
    vecs[9]  = mk(8'd0,   32'h05050505, 32'h05050505, 16'h0000, 1'b0);
    vecs[10] = mk(8'd3,   32'h02020202, 32'h03030303, 16'd72,   1'b0);
    vecs[11] = mk(8'd1,   32'h05FD07FE, 32'hFC060209, Relu ? 16'h0000 : 16'hFFD6, 1'b0);

    CLR_MAC = 1'b1; START = 1'b0; DATA_VALID = 1'b0; NUM_BEATS = '0;
    set_lanes('0, '0);
    tick(); tick();
    CLR_MAC = 1'b0;
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    check("reset result", 32'(RESULT), 32'd0);
    check("reset sat", 32'(SAT_FLAG), 32'd0);

    for (int i = 0; i < 12; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Stalled accumulation: valid 1,0,1,0,1; DONE one edge after the third beat.
    set_lanes(32'h02020202, 32'h03030303);
    START = 1'b1; NUM_BEATS = 8'd3; tick();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      DATA_VALID = (i % 2 == 0);
      tick();
      if (i < 4) check($sformatf("stall busy%0d", i), 32'(BUSY), 32'd1);
    end
    DATA_VALID = 1'b0;
    check("stall done_early", 32'(DONE), 32'd0);
    tick();
    check("stall done", 32'(DONE), 32'd1);
    check("stall result", 32'(RESULT), 32'd72);

    // DATA_VALID in idle has no effect; then a zero-beat job with valid still high.
    set_lanes(32'h7F7F7F7F, 32'h7F7F7F7F);
    DATA_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_valid done%0d", i), 32'(DONE), 32'd0);
      check($sformatf("idle_valid result%0d", i), 32'(RESULT), 32'd72);
    end
    START = 1'b1; NUM_BEATS = 8'd0; tick();
    START = 1'b0;
    check("zero done_early", 32'(DONE), 32'd0);
    tick();
    check("zero done", 32'(DONE), 32'd1);
    check("zero result", 32'(RESULT), 32'd0);
    DATA_VALID = 1'b0;

    // START pulses in ACC and FIN are ignored; START one cycle after DONE is accepted.
    set_lanes(32'h01010101, 32'h01010101);
    START = 1'b1; NUM_BEATS = 8'd2; tick();
    START = 1'b0; DATA_VALID = 1'b1; tick();
    DATA_VALID = 1'b0; START = 1'b1; NUM_BEATS = 8'd5; tick();
    START = 1'b0; DATA_VALID = 1'b1; tick();
    DATA_VALID = 1'b0; START = 1'b1; NUM_BEATS = 8'd3;
    check("ign done_early", 32'(DONE), 32'd0);
    tick();
    START = 1'b0;
    check("ign done", 32'(DONE), 32'd1);
    check("ign busy", 32'(BUSY), 32'd0);
    check("ign result", 32'(RESULT), 32'd8);
    tick();
    check("ign no_restart", 32'(BUSY), 32'd0);
    set_lanes(32'h01020304, 32'h05060708);
    START = 1'b1; NUM_BEATS = 8'd1; tick();
    START = 1'b0;
    check("restart busy", 32'(BUSY), 32'd1);
    DATA_VALID = 1'b1; tick();
    DATA_VALID = 1'b0; tick();
    check("restart done", 32'(DONE), 32'd1);
    check("restart result", 32'(RESULT), 32'd70);

    // Reset mid-job abandons it with no DONE; the next job starts from a clean state.
    set_lanes(32'h01010101, 32'h01010101);
    START = 1'b1; NUM_BEATS = 8'd4; tick();
    START = 1'b0; DATA_VALID = 1'b1; tick(); tick();
    DATA_VALID = 1'b0; CLR_MAC = 1'b1; tick();
    CLR_MAC = 1'b0;
    check("midrst busy", 32'(BUSY), 32'd0);
    check("midrst result", 32'(RESULT), 32'd0);
    check("midrst done", 32'(DONE), 32'd0);
    DATA_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("midrst no_done%0d", i), 32'(DONE), 32'd0);
    end
    DATA_VALID = 1'b0;
    run_job(vecs[1], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
